sched_logic_eval: RTL
=====================

SCHED_LOGIC_EVAL -- requirements
Module: sched_logic_eval

Interface
REQ-001 Parameter WIDTH, default 4, number of independent bit lanes evaluated per job.
REQ-002 Parameter MODE, default 1, schedule select: 0 = unconstrained (ASAP), 1 = resource-constrained (one AND, one OR, one NOT unit).
REQ-003 clk  input  1  sole clock, all state on rising edge.
REQ-004 rst  input  1  asynchronous active-low reset.
REQ-005 clr  input  1  synchronous abort, returns block to IDLE.
REQ-006 in_valid  input  1  job offered on a..f.
REQ-007 in_ready  output  1  block accepts a job this cycle.
REQ-008 a, b, c, d, e, f  input  WIDTH each  job operands.
REQ-009 out_valid  output  1  o, p, q hold a completed result.
REQ-010 out_ready  input  1  consumer takes result.
REQ-011 o, p, q  output  WIDTH each  registered results.
REQ-012 step  output  3  current schedule step, 0 outside EXEC.
REQ-013 job_cnt  output  8  completed-job count.

Function
REQ-014 Per lane, the block SHALL compute: g=a|d; h=a&c; i=~c; j=d|e|f; k=g|h|i; l=h&i&j; m=i&j; n=l&m; o=b&h&k; p=~g; q=~n.
REQ-015 Intermediates g..n SHALL be WIDTH-bit registers written only in the step assigned to them; no step SHALL read a value produced in the same step.
REQ-016 MODE 0 schedule SHALL be: step1 g,h,i,j; step2 k,l,m,p; step3 n,o; step4 q (S=4).
REQ-017 MODE 1 schedule SHALL be: step1 h,g,i; step2 j,p; step3 l,k; step4 m; step5 n; step6 o,q (S=6); at most one AND-, one OR-, one NOT-type operation per step.
REQ-018 FSM states SHALL be IDLE, EXEC, DONE.
REQ-019 in_ready SHALL equal 1 only in IDLE with clr=0.
REQ-020 IDLE: in_valid=1 and in_ready=1 at an edge SHALL capture a..f and enter EXEC with step=1.
REQ-021 EXEC: each edge SHALL commit the current step's results and increment step; the edge committing step S SHALL enter DONE.
REQ-022 out_valid SHALL rise exactly S edges after the accepting edge (4 in MODE 0, 6 in MODE 1).
REQ-023 o, p, q SHALL change only at the edge entering DONE and SHALL hold their value otherwise, including after out_valid falls.
REQ-024 DONE: out_valid=1 until an edge with out_ready=1, which SHALL return to IDLE and increment job_cnt (wraps 255->0).
REQ-025 in_valid during EXEC or DONE SHALL be ignored; no job overlap; a new job is accepted no earlier than the edge after DONE exits.
REQ-026 clr=1 at an edge SHALL force IDLE and step=0 from any state, discard any in-flight job, leave o/p/q and job_cnt unchanged, and take priority over accept and out_ready.
REQ-027 a..f changing after capture SHALL NOT affect the job in flight.

Reset
REQ-028 rst=0 SHALL immediately force IDLE, step=0, out_valid=0, o=p=q=0, job_cnt=0, intermediates=0, independent of clk.
REQ-029 After rst deassertion, in_ready SHALL be 1 in the first cycle with clr=0.
REQ-030 rst asserted mid-EXEC or in DONE SHALL drop the job with no output update.

Verification
REQ-031 WIDTH=4, MODE=1: a=1010 b=1111 c=1100 d=0000 e=0000 f=0001 -> out_valid 6 edges after accept, o=1000 p=0101 q=1111, job_cnt=1 after out_ready.
REQ-032 MODE=0, all operands 1111 -> out_valid after 4 edges, o=1111 p=0000 q=1111; all operands 0000 -> o=0000 p=1111 q=1111.
REQ-033 out_ready held 0 for 10 cycles in DONE -> out_valid and o/p/q stable, in_ready=0, in_valid pulses ignored; out_ready=1 -> IDLE next edge.
REQ-034 clr=1 at step 3 of a job -> step=0, in_ready=1 next cycle, o/p/q retain prior result, job_cnt unchanged.
REQ-035 rst pulsed low mid-EXEC between clock edges -> outputs zero immediately, out_valid never asserts for that job.
REQ-036 256 back-to-back jobs with out_ready=1 -> job_cnt wraps to 0; every result matches REQ-014 per lane.

Source files
------------

// File: rtl/sched_logic_eval.sv
// Purpose: evaluates a fixed lane-wise boolean network as a scheduled job (ASAP or one AND/OR/NOT unit per step).
// Latency: result valid exactly 4 (MODE 0) or 6 (MODE 1) edges after the accepting edge.
// Backpressure: one job in flight; in_ready low outside IDLE, result held in DONE until out_ready.
module sched_logic_eval #(
  parameter int WIDTH = 4,
  parameter int MODE  = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [WIDTH-1:0] c,
  input  logic [WIDTH-1:0] d,
  input  logic [WIDTH-1:0] e,
  input  logic [WIDTH-1:0] f,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] o,
  output logic [WIDTH-1:0] p,
  output logic [WIDTH-1:0] q,
  output logic [2:0]       step,
  output logic [7:0]       job_cnt
);

  localparam logic [2:0] LAST_STEP = (MODE == 0) ? 3'd4 : 3'd6;

  typedef enum logic [1:0] {IDLE, EXEC, DONE} state_t;

  state_t r_state, w_next;
  logic [2:0] r_step;
  logic [7:0] r_job_cnt;
  logic [WIDTH-1:0] r_a, r_b, r_c, r_d, r_e, r_f;
  logic [WIDTH-1:0] r_g, r_h, r_i, r_j, r_k, r_l, r_m, r_n;
  // results computed before the final step wait here so o/p/q only move when entering DONE
  logic [WIDTH-1:0] r_to, r_tp, r_tq;
  logic [WIDTH-1:0] r_o, r_p, r_q;

  logic w_accept, w_exec, w_last, w_release;
  logic w_en_g, w_en_h, w_en_i, w_en_j, w_en_k, w_en_l, w_en_m, w_en_n;
  logic w_en_o, w_en_p, w_en_q;
  logic [WIDTH-1:0] w_g, w_h, w_i, w_j, w_k, w_l, w_m, w_n, w_o, w_p, w_q;

  // every operator reads only registers, so a step never sees its own results
  assign w_g = r_a | r_d;
  assign w_h = r_a & r_c;
  assign w_i = ~r_c;
  assign w_j = r_d | r_e | r_f;
  assign w_k = r_g | r_h | r_i;
  assign w_l = r_h & r_i & r_j;
  assign w_m = r_i & r_j;
  assign w_n = r_l & r_m;
  assign w_o = r_b & r_h & r_k;
  assign w_p = ~r_g;
  assign w_q = ~r_n;

  assign w_accept  = (r_state == IDLE) && in_valid && !clr;
  assign w_exec    = (r_state == EXEC) && !clr;
  assign w_last    = w_exec && (r_step == LAST_STEP);
  assign w_release = (r_state == DONE) && out_ready && !clr;

  assign in_ready  = (r_state == IDLE) && !clr;
  assign out_valid = (r_state == DONE);
  assign o         = r_o;
  assign p         = r_p;
  assign q         = r_q;
  assign step      = r_step;
  assign job_cnt   = r_job_cnt;

  // decode which intermediates the current step commits
  always_comb begin
    w_en_g = 1'b0; w_en_h = 1'b0; w_en_i = 1'b0; w_en_j = 1'b0;
    w_en_k = 1'b0; w_en_l = 1'b0; w_en_m = 1'b0; w_en_n = 1'b0;
    w_en_o = 1'b0; w_en_p = 1'b0; w_en_q = 1'b0;
    if (r_state == EXEC) begin
      if (MODE == 0) begin
        case (r_step)
          3'd1: begin w_en_g = 1'b1; w_en_h = 1'b1; w_en_i = 1'b1; w_en_j = 1'b1; end
          3'd2: begin w_en_k = 1'b1; w_en_l = 1'b1; w_en_m = 1'b1; w_en_p = 1'b1; end
          3'd3: begin w_en_n = 1'b1; w_en_o = 1'b1; end
          3'd4: begin w_en_q = 1'b1; end
          default: ;
        endcase
      end else begin
        case (r_step)
          3'd1: begin w_en_h = 1'b1; w_en_g = 1'b1; w_en_i = 1'b1; end
          3'd2: begin w_en_j = 1'b1; w_en_p = 1'b1; end
          3'd3: begin w_en_l = 1'b1; w_en_k = 1'b1; end
          3'd4: begin w_en_m = 1'b1; end
          3'd5: begin w_en_n = 1'b1; end
          3'd6: begin w_en_o = 1'b1; w_en_q = 1'b1; end
          default: ;
        endcase
      end
    end
  end

  // state register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_state <= IDLE;
    else      r_state <= w_next;
  end

  // next-state: clr overrides everything, then accept / last step / release
  always_comb begin
    w_next = r_state;
    if (clr) begin
      w_next = IDLE;
    end else begin
      case (r_state)
        IDLE:    if (in_valid) w_next = EXEC;
        EXEC:    if (r_step == LAST_STEP) w_next = DONE;
        DONE:    if (out_ready) w_next = IDLE;
        default: w_next = IDLE;
      endcase
    end
  end

  // step counter: 1..LAST_STEP inside EXEC, 0 elsewhere
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)          r_step <= 3'd0;
    else if (clr)      r_step <= 3'd0;
    else if (w_accept) r_step <= 3'd1;
    else if (w_last)   r_step <= 3'd0;
    else if (w_exec)   r_step <= r_step + 3'd1;
  end

  // operand capture decouples the job from later input changes
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_a <= '0; r_b <= '0; r_c <= '0; r_d <= '0; r_e <= '0; r_f <= '0;
    end else if (w_accept) begin
      r_a <= a; r_b <= b; r_c <= c; r_d <= d; r_e <= e; r_f <= f;
    end
  end

  // intermediates and early results commit only in their scheduled step
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_g <= '0; r_h <= '0; r_i <= '0; r_j <= '0;
      r_k <= '0; r_l <= '0; r_m <= '0; r_n <= '0;
      r_to <= '0; r_tp <= '0; r_tq <= '0;
    end else if (w_exec) begin
      if (w_en_g) r_g <= w_g;
      if (w_en_h) r_h <= w_h;
      if (w_en_i) r_i <= w_i;
      if (w_en_j) r_j <= w_j;
      if (w_en_k) r_k <= w_k;
      if (w_en_l) r_l <= w_l;
      if (w_en_m) r_m <= w_m;
      if (w_en_n) r_n <= w_n;
      if (w_en_o) r_to <= w_o;
      if (w_en_p) r_tp <= w_p;
      if (w_en_q) r_tq <= w_q;
    end
  end

  // visible results load once, on the edge entering DONE
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_o <= '0; r_p <= '0; r_q <= '0;
    end else if (w_last) begin
      r_o <= w_en_o ? w_o : r_to;
      r_p <= w_en_p ? w_p : r_tp;
      r_q <= w_en_q ? w_q : r_tq;
    end
  end

  // completed-job counter, wraps naturally at 8 bits
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)           r_job_cnt <= 8'd0;
    else if (w_release) r_job_cnt <= r_job_cnt + 8'd1;
  end

endmodule
